// File: rtl/reg_universal_if.sv
// Control/data bundle for reg_universal: master drives the controls and data,
// slave returns q, qbar, co and the gated bus copy.
interface reg_universal_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned MODE_W = 3;

  logic              preset;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  d;
  logic              ser_l;
  logic              ser_r;
  logic              oe;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  qbar;
  logic              co;
  wire  [WIDTH-1:0]  bus_out;

  modport master (
    output preset, mode, d, ser_l, ser_r, oe,
    input  q, qbar, co, bus_out
  );

  modport slave (
    input  preset, mode, d, ser_l, ser_r, oe,
    output q, qbar, co, bus_out
  );
endinterface

// File: rtl/reg_universal.sv
// Universal register: load/shift/rotate/inc/dec with sync clear and preset.
// Define REG_UNIVERSAL_TRISTATE_EN to float bus_out when oe=0 (default: zeros).
module reg_universal #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           clear,
  reg_universal_if.slave bus
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROTL = 3'd4,
    OP_ROTR = 3'd5,
    OP_INC  = 3'd6,
    OP_DEC  = 3'd7
  } op_e;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             co_q;
  logic             co_d;
  op_e              op;

  assign op = op_e'(bus.mode);

  // Next value: preset beats mode; clear is applied in the register stage.
  always_comb begin
    q_d  = q_q;
    co_d = co_q;
    if (bus.preset) begin
      q_d  = ALL_ONES;
      co_d = 1'b0;
    end else begin
      unique case (op)
        OP_HOLD: begin
          q_d  = q_q;
          co_d = co_q;
        end
        OP_LOAD: begin
          q_d  = bus.d;
          co_d = 1'b0;
        end
        OP_SHL: begin
          q_d  = {q_q[WIDTH-2:0], bus.ser_l};
          co_d = q_q[WIDTH-1];
        end
        OP_SHR: begin
          q_d  = {bus.ser_r, q_q[WIDTH-1:1]};
          co_d = q_q[0];
        end
        OP_ROTL: begin
          q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          co_d = q_q[WIDTH-1];
        end
        OP_ROTR: begin
          q_d  = {q_q[0], q_q[WIDTH-1:1]};
          co_d = q_q[0];
        end
        OP_INC: begin
          {co_d, q_d} = {1'b0, q_q} + (WIDTH+1)'(1);
        end
        OP_DEC: begin
          q_d  = q_q - WIDTH'(1);
          co_d = (q_q == ALL_ZERO);
        end
        default: begin
          q_d  = q_q;
          co_d = co_q;
        end
      endcase
    end
  end

  // Synchronous clear has top priority; no asynchronous path.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q  <= RESET_VALUE;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.co   = co_q;

`ifdef REG_UNIVERSAL_TRISTATE_EN
  assign bus.bus_out = bus.oe ? q_q : {WIDTH{1'bz}};
`else
  // Zeros when disabled so several sources can be OR-combined.
  assign bus.bus_out = bus.oe ? q_q : ALL_ZERO;
`endif

endmodule

// File: doc/reg_universal.md
REG_UNIVERSAL -- requirements
Module: reg_universal

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, giving the register width in bits (legal range 2..32).
REQ-002 The block SHALL provide parameter RESET_VALUE, default 0, as the WIDTH-bit value loaded by clear.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clear  input  1  synchronous, active-high reset.
REQ-005 preset  input  1  synchronous, active-high; sets q to all ones.
REQ-006 mode  input  3  operation select, sampled at the rising edge of clk.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 ser_l  input  1  serial input entering bit 0 on shift-left.
REQ-009 ser_r  input  1  serial input entering bit WIDTH-1 on shift-right.
REQ-010 oe  input  1  bus output enable.
REQ-011 q  output  WIDTH  registered value.
REQ-012 qbar  output  WIDTH  bitwise complement of q, combinational.
REQ-013 co  output  1  registered carry/shift-out flag.
REQ-014 bus_out  output  WIDTH  bus-side copy of q, gated by oe (see Configuration).

Function
REQ-015 Per-edge priority SHALL be: clear, then preset, then mode.
REQ-016 mode encoding SHALL be: 0 hold, 1 load, 2 shl, 3 shr, 4 rotl, 5 rotr, 6 inc, 7 dec.
REQ-017 hold: q and co SHALL be unchanged.
REQ-018 load: q SHALL become d, and co SHALL become 0.
REQ-019 shl: q SHALL become {q[WIDTH-2:0], ser_l}, and co SHALL become the old q[WIDTH-1].
REQ-020 shr: q SHALL become {ser_r, q[WIDTH-1:1]}, and co SHALL become the old q[0].
REQ-021 rotl/rotr: q SHALL rotate by one bit, and co SHALL become the bit that wrapped.
REQ-022 inc: q SHALL become q+1 modulo 2^WIDTH, and co SHALL be 1 exactly when old q was all ones (wrap to 0).
REQ-023 dec: q SHALL become q-1 modulo 2^WIDTH, and co SHALL be 1 exactly when old q was 0 (wrap to all ones).
REQ-024 All operations SHALL have one-cycle latency: the result is visible on q/co after the same rising edge.
REQ-025 preset SHALL set q to all ones and co to 0, ignoring mode.
REQ-026 qbar SHALL equal ~q at all times, including during and after reset.
REQ-027 Changes on d, ser_l, ser_r or mode between edges SHALL NOT affect q or co.

Reset
REQ-028 While clear is high at a rising edge, q SHALL become RESET_VALUE and co SHALL become 0, regardless of preset and mode.
REQ-029 Reset SHALL NOT act asynchronously; before the first clocked clear, q is undefined.
REQ-030 Asserting clear mid-sequence, for example during an inc run, SHALL abort the sequence on that edge; the operation resumes from RESET_VALUE after clear is released.

Configuration
REQ-031 With macro REG_UNIVERSAL_TRISTATE_EN defined, bus_out SHALL equal q when oe=1 and high-impedance on all bits when oe=0.
REQ-032 Without REG_UNIVERSAL_TRISTATE_EN, bus_out SHALL equal q when oe=1 and all zeros when oe=0, so that it can be OR-combined onto a shared bus.
REQ-033 oe SHALL affect only bus_out and never q, qbar or co.

Verification
REQ-034 Reset: WIDTH=8, RESET_VALUE=8'h5A, clear=1 with preset=1 and mode=1 for one edge -> q=8'h5A, qbar=8'hA5, co=0.
REQ-035 Load/shift: load 8'h81; then shl with ser_l=0 -> q=8'h02, co=1; then shr with ser_r=1 -> q=8'h81, co=0.
REQ-036 Rotate: load 8'h01, then rotr -> q=8'h80, co=1; then rotl -> q=8'h01, co=1.
REQ-037 Wrap: load 8'hFE, then inc twice -> q=8'hFF with co=0, then q=8'h00 with co=1; then dec -> q=8'hFF, co=1; then hold -> q and co unchanged.
REQ-038 Priority and bus: preset=1 with mode=6 -> q=8'hFF, co=0; oe=0 -> bus_out=8'hZZ with the macro and 8'h00 without it; oe=1 -> bus_out=8'hFF.
REQ-039 Mid-run reset: run inc from 8'h10 for 3 edges, assert clear on the 4th edge -> q=RESET_VALUE, then inc resumes from RESET_VALUE+1.
